// File: rtl/ch_threshold_search_if.sv
// ch_threshold_search_if
//   Bundles the DAC write handshake and the waveform point output of one
//   measurement channel's threshold sweep controller.
//   master : the sweep controller (drives threshold/point, reads DAC ready)
//   slave  : the DAC SPI master / point consumer side
//   threshold_o     DAC code to write
//   threshold_wre_o one-cycle DAC write request
//   threshold_rdy_i DAC SPI master idle
//   point_rdy_o     one-cycle point valid
//   point_v_o       point threshold value
//   point_t_o       point delay code
interface ch_threshold_search_if #(
    parameter int DAC_CODE_WIDTH = 16,
    parameter int DCODE_WIDTH    = 10
);
    logic [DAC_CODE_WIDTH-1:0] threshold_o;
    logic                      threshold_wre_o;
    logic                      threshold_rdy_i;
    logic                      point_rdy_o;
    logic [DAC_CODE_WIDTH-1:0] point_v_o;
    logic [DCODE_WIDTH-1:0]    point_t_o;

    modport master (
        output threshold_o, threshold_wre_o, point_rdy_o, point_v_o, point_t_o,
        input  threshold_rdy_i
    );

    modport slave (
        input  threshold_o, threshold_wre_o, point_rdy_o, point_v_o, point_t_o,
        output threshold_rdy_i
    );
endinterface

// File: rtl/ch_threshold_search.sv
// ch_threshold_search
//   Equivalent-time sweep controller for one measurement channel. For every
//   delay-line code it ramps the comparator threshold until the comparator
//   reads low at the strobe instant, then emits one (threshold, code) point.
//   clk_i, rst_i          clock, synchronous active-high reset
//   run_i, abort_i        start / abort pulses
//   stb_i                 single-cycle strobe (same clock domain)
//   cmp_out_i             comparator output
//   threshold_delta_i     threshold step, latched at start
//   d_code_delta_i        delay-code step, latched at start
//   d_code_o              delay-line code
//   busy_o, done_o        sweep in progress / one-cycle completion pulse
//   dac_if                DAC handshake and point output (master side)
//
// state      | meaning
// IDLE       | waiting for run_i
// DAC_WR     | waiting for DAC idle, then issue write request
// DAC_WAIT   | waiting for DAC to finish the write (first cycle ignored)
// SETTLE     | analog settling after DAC update
// WAIT_STB   | armed, waiting for the strobe
// SAMPLE     | counting from strobe to comparator sample instant
// POINT      | point emitted, advance delay code
// DONE       | one-cycle completion
module ch_threshold_search #(
    parameter int DAC_CODE_WIDTH = 16,
    parameter int DCODE_WIDTH    = 10,
    parameter int SETTLE_CYCLES  = 8,
    parameter int SAMPLE_DELAY   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      run_i,
    input  logic                      abort_i,
    input  logic                      stb_i,
    input  logic                      cmp_out_i,
    input  logic [DAC_CODE_WIDTH-1:0] threshold_delta_i,
    input  logic [DCODE_WIDTH-1:0]    d_code_delta_i,
    output logic [DCODE_WIDTH-1:0]    d_code_o,
    output logic                      busy_o,
    output logic                      done_o,
    ch_threshold_search_if.master     dac_if
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_DELAY) ? SETTLE_CYCLES : SAMPLE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DAC_WR, S_DAC_WAIT, S_SETTLE, S_WAIT_STB, S_SAMPLE, S_POINT, S_DONE
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [DAC_CODE_WIDTH-1:0] r_thr, w_thr_nxt;
    logic [DAC_CODE_WIDTH-1:0] r_tdelta, w_tdelta_nxt;
    logic [DCODE_WIDTH-1:0]    r_dcode, w_dcode_nxt;
    logic [DCODE_WIDTH-1:0]    r_ddelta, w_ddelta_nxt;
    logic [DAC_CODE_WIDTH-1:0] r_pv, w_pv_nxt;
    logic [DCODE_WIDTH-1:0]    r_pt, w_pt_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_wre, w_wre_nxt;
    logic                      r_prdy, w_prdy_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_first, w_first_nxt;
    logic                      w_decide;
    logic [DAC_CODE_WIDTH:0]   w_thr_sum;
    logic [DCODE_WIDTH:0]      w_dcode_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_thr    <= '0;
            r_tdelta <= '0;
            r_dcode  <= '0;
            r_ddelta <= '0;
            r_pv     <= '0;
            r_pt     <= '0;
            r_cnt    <= '0;
            r_wre    <= 1'b0;
            r_prdy   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_thr    <= w_thr_nxt;
            r_tdelta <= w_tdelta_nxt;
            r_dcode  <= w_dcode_nxt;
            r_ddelta <= w_ddelta_nxt;
            r_pv     <= w_pv_nxt;
            r_pt     <= w_pt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wre    <= w_wre_nxt;
            r_prdy   <= w_prdy_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_first  <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_thr_nxt    = r_thr;
        w_tdelta_nxt = r_tdelta;
        w_dcode_nxt  = r_dcode;
        w_ddelta_nxt = r_ddelta;
        w_pv_nxt     = r_pv;
        w_pt_nxt     = r_pt;
        w_cnt_nxt    = r_cnt;
        w_wre_nxt    = 1'b0;
        w_prdy_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_first_nxt  = r_first;
        w_decide     = 1'b0;
        // One extra bit on each sum exposes the overflow / end-of-range carry.
        w_thr_sum    = {1'b0, r_thr} + {1'b0, r_tdelta};
        w_dcode_sum  = {1'b0, r_dcode} + {1'b0, r_ddelta};

        case (r_state)
            S_IDLE: begin
                if (run_i && !abort_i) begin
                    // A zero step would never advance; treat it as a step of one.
                    w_tdelta_nxt = (threshold_delta_i == '0) ? DAC_CODE_WIDTH'(1) : threshold_delta_i;
                    w_ddelta_nxt = (d_code_delta_i == '0) ? DCODE_WIDTH'(1) : d_code_delta_i;
                    w_thr_nxt    = '0;
                    w_dcode_nxt  = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_DAC_WR;
                end
            end
            S_DAC_WR: begin
                if (dac_if.threshold_rdy_i) begin
                    w_wre_nxt   = 1'b1;
                    w_first_nxt = 1'b1;
                    w_state_nxt = S_DAC_WAIT;
                end
            end
            S_DAC_WAIT: begin
                // The SPI master may still report idle on the cycle it sees the request.
                if (r_first) begin
                    w_first_nxt = 1'b0;
                end else if (dac_if.threshold_rdy_i) begin
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_STB;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WAIT_STB: begin
                if (stb_i) begin
                    if (SAMPLE_DELAY == 0) begin
                        w_decide = 1'b1;
                    end else begin
                        w_cnt_nxt   = SAMPLE_LOAD;
                        w_state_nxt = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_decide = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_POINT: begin
                if (w_dcode_sum[DCODE_WIDTH]) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_dcode_nxt = w_dcode_sum[DCODE_WIDTH-1:0];
                    w_thr_nxt   = '0;
                    w_state_nxt = S_DAC_WR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_decide) begin
            if (cmp_out_i && !w_thr_sum[DAC_CODE_WIDTH]) begin
                w_thr_nxt   = w_thr_sum[DAC_CODE_WIDTH-1:0];
                w_state_nxt = S_DAC_WR;
            end else begin
                // Comparator never went low within range: report full scale.
                w_pv_nxt    = cmp_out_i ? '1 : r_thr;
                w_pt_nxt    = r_dcode;
                w_prdy_nxt  = 1'b1;
                w_state_nxt = S_POINT;
            end
        end

        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_thr_nxt   = r_thr;
            w_dcode_nxt = r_dcode;
            w_pv_nxt    = r_pv;
            w_pt_nxt    = r_pt;
            w_wre_nxt   = 1'b0;
            w_prdy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
        end
    end

    assign dac_if.threshold_o     = r_thr;
    assign dac_if.threshold_wre_o = r_wre;
    assign dac_if.point_rdy_o     = r_prdy;
    assign dac_if.point_v_o       = r_pv;
    assign dac_if.point_t_o       = r_pt;
    assign d_code_o               = r_dcode;
    assign busy_o                 = r_busy;
    assign done_o                 = r_done;

endmodule

// File: tb/tb_ch_threshold_search.sv
module tb_ch_threshold_search;
    localparam int DW     = 16;
    localparam int CW     = 10;
    localparam int SETTLE = 8;
    localparam int SD     = 2;
    localparam int DMAX   = (1 << DW) - 1;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, run, abort, stb_man, stb_gen, stb, cmp;
    logic [DW-1:0] tdelta;
    logic [CW-1:0] ddelta, d_code;
    logic          busy, done;

    ch_threshold_search_if #(.DAC_CODE_WIDTH(DW), .DCODE_WIDTH(CW)) dac_if ();

    ch_threshold_search #(
        .DAC_CODE_WIDTH(DW), .DCODE_WIDTH(CW),
        .SETTLE_CYCLES(SETTLE), .SAMPLE_DELAY(SD)
    ) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .run_i             (run),
        .abort_i           (abort),
        .stb_i             (stb),
        .cmp_out_i         (cmp),
        .threshold_delta_i (tdelta),
        .d_code_delta_i    (ddelta),
        .d_code_o          (d_code),
        .busy_o            (busy),
        .done_o            (done),
        .dac_if            (dac_if)
    );

    assign stb = stb_gen | stb_man;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_wr[$];
    int exp_pv[$];
    int exp_pt[$];
    int cmp_mode, cmp_lim, cmp_step;
    int stb_period;
    int dac_cnt = 0;
    int stb_cnt = 0;
    int tcyc = 0;
    int last_pt_cyc, n_pt_seen, n_pt_exp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Comparator stimulus: reads high while the threshold is below the trip level.
    function automatic bit cmp_fn(input int thr, input int d);
        case (cmp_mode)
            0:       return thr < cmp_lim;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return thr < (cmp_lim + (d >> 8) * cmp_step);
        endcase
    endfunction

    // Reference: the list of DAC writes and points a complete sweep must produce.
    task automatic build_expect(input int td, input int dd);
        int tde, dde, thr, v;
        exp_wr.delete();
        exp_pv.delete();
        exp_pt.delete();
        tde = (td == 0) ? 1 : td;
        dde = (dd == 0) ? 1 : dd;
        for (int d = 0; d <= CMAX; d += dde) begin
            thr = 0;
            while (1) begin
                exp_wr.push_back(thr);
                if (!cmp_fn(thr, d)) begin v = thr; break; end
                if (thr + tde > DMAX) begin v = DMAX; break; end
                thr += tde;
            end
            exp_pv.push_back(v);
            exp_pt.push_back(d);
        end
    endtask

    // Stimulus drivers, DAC model and scoreboard, all away from the active edge.
    always @(negedge clk) begin
        cmp = cmp_fn(int'(dac_if.threshold_o), int'(d_code));
        if (dac_if.threshold_wre_o) dac_cnt = 5;
        else if (dac_cnt != 0) dac_cnt = dac_cnt - 1;
        dac_if.threshold_rdy_i = (dac_cnt == 0);
        if (stb_period != 0) begin
            stb_cnt = stb_cnt + 1;
            if (stb_cnt >= stb_period) begin stb_cnt = 0; stb_gen = 1'b1; end
            else stb_gen = 1'b0;
        end else begin
            stb_cnt = 0;
            stb_gen = 1'b0;
        end
        if (!rst) begin
            if (dac_if.threshold_wre_o) begin
                if (exp_wr.size() == 0) check_val("wre_unexpected", 32'(exp_wr.size()), 32'd1);
                else check_val("wre_thr", 32'(dac_if.threshold_o), 32'(exp_wr.pop_front()));
            end
            if (dac_if.point_rdy_o) begin
                if (exp_pv.size() == 0) check_val("point_unexpected", 32'(exp_pv.size()), 32'd1);
                else begin
                    check_val("point_v", 32'(dac_if.point_v_o), 32'(exp_pv.pop_front()));
                    check_val("point_t", 32'(dac_if.point_t_o), 32'(exp_pt.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        tcyc++;
        if (dac_if.point_rdy_o) begin
            n_pt_seen++;
            last_pt_cyc = tcyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_expect();
        exp_wr.delete();
        exp_pv.delete();
        exp_pt.delete();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_thr",   32'(dac_if.threshold_o), 32'd0);
        check_val("rst_wre",   32'(dac_if.threshold_wre_o), 32'd0);
        check_val("rst_dcode", 32'(d_code), 32'd0);
        check_val("rst_prdy",  32'(dac_if.point_rdy_o), 32'd0);
        check_val("rst_pv",    32'(dac_if.point_v_o), 32'd0);
        check_val("rst_pt",    32'(dac_if.point_t_o), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
    endtask

    // Pulse run and check start latency; returns on the cycle of the first write.
    task automatic start_sweep(input int td, input int dd);
        build_expect(td, dd);
        n_pt_exp  = exp_pv.size();
        n_pt_seen = 0;
        tdelta    = DW'(td);
        ddelta    = CW'(dd);
        run       = 1'b1;
        step();
        run = 1'b0;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_wre_early", 32'(dac_if.threshold_wre_o), 32'd0);
        check_val("start_thr", 32'(dac_if.threshold_o), 32'd0);
        check_val("start_dcode", 32'(d_code), 32'd0);
        step();
        check_val("start_wre_n2", 32'(dac_if.threshold_wre_o), 32'd1);
    endtask

    task automatic finish_sweep(input int budget);
        bit got_done;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin got_done = 1'b1; break; end
        end
        check_val("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check_val("done_busy_low", 32'(busy), 32'd0);
            check_val("done_after_point", 32'(tcyc - last_pt_cyc), 32'd1);
            check_val("point_count", 32'(n_pt_seen), 32'(n_pt_exp));
            check_val("writes_left", 32'(exp_wr.size()), 32'd0);
            step();
            check_val("done_pulse_len", 32'(done), 32'd0);
        end
        idle(10);
    endtask

    task automatic abort_and_check();
        int ev;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        ev = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (dac_if.point_rdy_o || done || dac_if.threshold_wre_o) ev++;
        end
        check_val("abort_quiet", 32'(ev), 32'd0);
        clear_expect();
    endtask

    task automatic wait_points(input int n, input string tag);
        int i;
        for (i = 0; i < 5000 && n_pt_seen < n; i++) step();
        check_val(tag, 32'(n_pt_seen >= n), 32'd1);
    endtask

    initial begin
        int ev, td, dd;
        bit moved;
        rst = 1'b1; run = 1'b1; abort = 1'b0; stb_man = 1'b0;
        tdelta = '0; ddelta = '0;
        cmp_mode = 0; cmp_lim = 3; cmp_step = 1; stb_period = 20;
        idle(4);
        rst = 1'b0; run = 1'b0;
        step();
        check_reset_outputs();
        idle(5);

        // Ramp: trip level 3, four delay codes, 16 writes.
        cmp_mode = 0; cmp_lim = 3; stb_period = 20;
        start_sweep(1, 'h100);
        finish_sweep(5000);

        // Threshold overflow reports full scale.
        cmp_mode = 1; stb_period = 9;
        start_sweep('h4000, 'h200);
        finish_sweep(5000);

        // Sweep end on delay-code carry.
        cmp_mode = 2; stb_period = 4;
        start_sweep(5, 'h200);
        finish_sweep(5000);

        // Early strobe during settling must not trigger a sample.
        cmp_mode = 0; cmp_lim = 1; stb_period = 0;
        start_sweep(1, 'h200);
        idle(8);
        stb_man = 1'b1;
        step();
        stb_man = 1'b0;
        ev = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (dac_if.threshold_wre_o || dac_if.point_rdy_o) ev++;
        end
        check_val("early_stb_ignored", 32'(ev), 32'd0);
        stb_period = 5;
        finish_sweep(5000);

        // Zero deltas step by one; abort after three points.
        cmp_mode = 0; cmp_lim = 3; stb_period = 3;
        start_sweep(0, 0);
        wait_points(3, "zero_delta_points");
        abort_and_check();
        idle(5);

        // Abort in DAC_WAIT after the code has advanced, then restart from zero.
        cmp_mode = 0; cmp_lim = 2; stb_period = 6;
        start_sweep(1, 'h100);
        wait_points(1, "abort_pre_point");
        moved = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (dac_if.threshold_wre_o) begin moved = 1'b1; break; end
        end
        check_val("abort_wre_seen", 32'(moved), 32'd1);
        abort_and_check();
        idle(5);
        start_sweep(1, 'h100);
        finish_sweep(5000);

        // Reset mid-sweep.
        cmp_mode = 0; cmp_lim = 3; stb_period = 7;
        start_sweep(1, 'h100);
        wait_points(1, "midrst_point");
        idle(3);
        rst = 1'b1;
        step();
        check_reset_outputs();
        rst = 1'b0;
        clear_expect();
        idle(10);

        // Randomized sweeps.
        for (int k = 0; k < 6; k++) begin
            cmp_mode   = int'($urandom_range(3, 0));
            stb_period = int'($urandom_range(25, 1));
            dd         = int'($urandom_range('h3FF, 'h100));
            if (cmp_mode == 1) td = int'($urandom_range('hFFFF, 'h2000));
            else td = int'($urandom_range('hFFFF, 0));
            cmp_step = (td == 0) ? 1 : td;
            cmp_lim  = int'($urandom_range(4 * cmp_step, 0));
            start_sweep(td, dd);
            finish_sweep(8000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
